// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned FAULT_BITS = 2;

  typedef logic [FAULT_BITS-1:0] fault_t;

  localparam fault_t FAULT_NONE     = 2'b00;
  localparam fault_t FAULT_MISALIGN = 2'b01;
  localparam fault_t FAULT_BUSERR   = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic            pending;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    fault_t          fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// In-order fetch buffer: entries are reserved at issue, filled by responses
// in order, and popped from the head; flush drops everything.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  fetch_entry_t    alloc_entry_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  fault_t          fill_fault_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [PW-1:0]   fill_ptr;

  // Pending entries always sit between the filled prefix and the tail, so a
  // dedicated fill pointer tracks the oldest one; pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
    end else begin
      if (pop_i) begin
        mem[head_ptr].valid <= 1'b0;
        head_ptr            <= head_ptr + PW'(1);
      end
      if (fill_i) begin
        mem[fill_ptr].data    <= fill_data_i;
        mem[fill_ptr].fault   <= fill_fault_i;
        mem[fill_ptr].pending <= 1'b0;
        fill_ptr              <= fill_ptr + PW'(1);
      end
      // Allocation last: a full ring may reuse the slot popped this cycle.
      if (alloc_i) begin
        mem[tail_ptr] <= alloc_entry_i;
        tail_ptr      <= tail_ptr + PW'(1);
      end
    end
  end

  assign head_o = mem[head_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues in-order memory requests from the PC unit,
// buffers responses for decode and steers the PC unit on redirects.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned FAULT_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [31:0]        pc_i,
  input  logic               pc_aligned_i,
  output logic               pc_en_o,
  output logic               pc_ld_o,
  output logic               pc_dr_o,
  output logic [31:0]        pc_ld_val_o,
  input  logic               redirect_i,
  input  logic               redirect_rel_i,
  input  logic [31:0]        redirect_val_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [31:0]        imem_rdata_i,
  input  logic               imem_err_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [31:0]        instr_o,
  output logic [31:0]        instr_pc_o,
  output logic [FAULT_W-1:0] instr_fault_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_e state, state_nx;
  logic [CW-1:0] occ, outst, kill;
  logic [SW-1:0] used;
  fetch_entry_t  head, alloc_entry;
  logic          head_ok, pop, room, run_ok, mis_push, issue, rsp, killed, fill;
  fault_t        fill_fault;

  // Slot accounting: filled entries plus in-flight requests (live or killed)
  // must stay below DEPTH; a same-cycle pop frees its slot for reuse.
  always_comb begin
    head_ok     = head.valid & ~head.pending;
    pop         = head_ok & instr_ready_i;
    used        = SW'(occ) + SW'(outst) - SW'(pop);
    room        = used < SW'(DEPTH);
    run_ok      = rst_ni & (state == ST_RUN) & ~redirect_i & room;
    mis_push    = run_ok & ~pc_aligned_i;
    issue       = run_ok & pc_aligned_i & imem_gnt_i;
    rsp         = imem_rvalid_i & (outst != '0);
    killed      = rsp & (kill != '0);
    fill        = rsp & ~killed & ~redirect_i;
    fill_fault  = imem_err_i ? FAULT_BUSERR : FAULT_NONE;
    alloc_entry = '{valid:   1'b1,
                    pending: issue,
                    pc:      pc_i,
                    data:    '0,
                    fault:   issue ? FAULT_NONE : FAULT_MISALIGN};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_RUN;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect_i)                         state_nx = ST_RUN;
    else if (state == ST_RUN && mis_push)   state_nx = ST_HALT;
  end

  always_comb begin
    imem_req_o    = run_ok & pc_aligned_i;
    imem_addr_o   = pc_i;
    pc_en_o       = issue | (rst_ni & redirect_i);
    pc_ld_o       = redirect_i;
    pc_dr_o       = redirect_rel_i;
    pc_ld_val_o   = redirect_val_i;
    instr_valid_o = head_ok;
    instr_o       = head_ok ? head.data : '0;
    instr_pc_o    = head_ok ? head.pc   : '0;
    instr_fault_o = head_ok ? FAULT_W'(head.fault) : '0;
  end

  // On redirect every in-flight response becomes a kill, except one
  // returning in the same cycle, which is simply dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ   <= '0;
      outst <= '0;
      kill  <= '0;
    end else if (redirect_i) begin
      occ   <= '0;
      outst <= outst - CW'(rsp);
      kill  <= outst - CW'(rsp);
    end else begin
      occ   <= occ + CW'(fill) + CW'(mis_push) - CW'(pop);
      outst <= outst + CW'(issue) - CW'(rsp);
      kill  <= kill - CW'(killed);
    end
  end

  ifetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (redirect_i),
    .alloc_i       (issue | mis_push),
    .alloc_entry_i (alloc_entry),
    .fill_i        (fill),
    .fill_data_i   (imem_rdata_i),
    .fill_fault_i  (fill_fault),
    .pop_i         (pop),
    .head_o        (head)
  );

endmodule
